// File: rtl/axis_pkg.sv
// Shared types and constants for the AXI-Stream 1:2 packet demultiplexer.
package axis_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT1 = 2'd1,
    PKT2 = 2'd2
  } state_e;

  localparam logic PORT_1 = 1'b0;
  localparam logic PORT_2 = 1'b1;

endpackage

// File: rtl/axis_fifo2.sv
// Two-entry {last, data} skid buffer feeding one master port; entry 0 is always the head.
module axis_fifo2
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  input  logic                  out_ready,
  output logic [1:0]            count,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  logic [DATA_WIDTH:0] ent_q [2];
  logic [DATA_WIDTH:0] ent_d [2];
  logic [1:0]          count_q;
  logic [1:0]          count_d;
  logic                pop_s;
  logic [DATA_WIDTH:0] new_s;

  // Next-state of the buffer: push appends behind the head, pop shifts entry 1 forward.
  always_comb begin
    ent_d   = ent_q;
    count_d = count_q;
    pop_s   = (count_q != 2'd0) && out_ready;
    new_s   = {push_last, push_data};
    case ({push, pop_s})
      2'b10: begin
        if (count_q == 2'd0) begin
          ent_d[0] = new_s;
          count_d  = 2'd1;
        end else if (count_q == 2'd1) begin
          ent_d[1] = new_s;
          count_d  = 2'd2;
        end else begin
          count_d = count_q;
        end
      end
      2'b01: begin
        ent_d[0] = ent_q[1];
        count_d  = count_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous push/pop keeps the count; the new beat lands behind any survivor.
        if (count_q == 2'd1) begin
          ent_d[0] = new_s;
        end else begin
          ent_d[0] = ent_q[1];
          ent_d[1] = new_s;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Buffer storage with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      count_q  <= 2'd0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = ent_q[0][DATA_WIDTH-1:0];
  assign out_last  = ent_q[0][DATA_WIDTH];

endmodule

// File: rtl/axis_demux_1_2.sv
// 1:2 AXI-Stream packet demultiplexer: sel is latched at packet start, each output is buffered.
module axis_demux_1_2
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sel,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_last,
  output logic [DATA_WIDTH-1:0] m_data_1,
  output logic                  m_valid_1,
  input  logic                  m_ready_1,
  output logic                  m_last_1,
  output logic [DATA_WIDTH-1:0] m_data_2,
  output logic                  m_valid_2,
  input  logic                  m_ready_2,
  output logic                  m_last_2
);

  state_e     state_q;
  state_e     state_d;
  logic       dest_s;
  logic       accept_s;
  logic [1:0] count_1_s;
  logic [1:0] count_2_s;

  // Destination and ready: only buffer counts and sel feed s_ready, never m_ready_x.
  always_comb begin
    dest_s = sel;
    case (state_q)
      IDLE:    dest_s = sel;
      PKT1:    dest_s = PORT_1;
      PKT2:    dest_s = PORT_2;
      default: dest_s = sel;
    endcase
    if (dest_s == PORT_1) begin
      s_ready = reset && (count_1_s < 2'd2);
    end else begin
      s_ready = reset && (count_2_s < 2'd2);
    end
    accept_s = s_valid && s_ready;
  end

  // Packet-lock FSM: leaves IDLE on the first non-last beat, returns on the last beat.
  always_comb begin
    state_d = state_q;
    if (accept_s) begin
      case (state_q)
        IDLE: begin
          if (s_last) begin
            state_d = IDLE;
          end else if (dest_s == PORT_2) begin
            state_d = PKT2;
          end else begin
            state_d = PKT1;
          end
        end
        PKT1, PKT2: begin
          if (s_last) begin
            state_d = IDLE;
          end else begin
            state_d = state_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  axis_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo_1 (
    .clk       (clk),
    .reset     (reset),
    .push      (accept_s && (dest_s == PORT_1)),
    .push_data (s_data),
    .push_last (s_last),
    .out_ready (m_ready_1),
    .count     (count_1_s),
    .out_valid (m_valid_1),
    .out_data  (m_data_1),
    .out_last  (m_last_1)
  );

  axis_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo_2 (
    .clk       (clk),
    .reset     (reset),
    .push      (accept_s && (dest_s == PORT_2)),
    .push_data (s_data),
    .push_last (s_last),
    .out_ready (m_ready_2),
    .count     (count_2_s),
    .out_valid (m_valid_2),
    .out_data  (m_data_2),
    .out_last  (m_last_2)
  );

endmodule

// File: tb/tb_axis_demux_1_2.sv
// Directed self-checking bench for axis_demux_1_2 with hand-computed expectations.
module tb_axis_demux_1_2;

  logic       clk;
  logic       reset;
  logic       sel;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       s_last;
  logic [7:0] m_data_1;
  logic       m_valid_1;
  logic       m_ready_1;
  logic       m_last_1;
  logic [7:0] m_data_2;
  logic       m_valid_2;
  logic       m_ready_2;
  logic       m_last_2;

  int n_assert;
  int n_fail;

  axis_demux_1_2 #(.DATA_WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_last    (s_last),
    .m_data_1  (m_data_1),
    .m_valid_1 (m_valid_1),
    .m_ready_1 (m_ready_1),
    .m_last_1  (m_last_1),
    .m_data_2  (m_data_2),
    .m_valid_2 (m_valid_2),
    .m_ready_2 (m_ready_2),
    .m_last_2  (m_last_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic s);
    s_valid = v;
    s_data  = d;
    s_last  = l;
    sel     = s;
  endtask

  initial begin
    logic [7:0] pkt_a [4];
    n_assert  = 0;
    n_fail    = 0;
    pkt_a[0]  = 8'h11;
    pkt_a[1]  = 8'h22;
    pkt_a[2]  = 8'h33;
    pkt_a[3]  = 8'h44;
    reset     = 1'b0;
    m_ready_1 = 1'b1;
    m_ready_2 = 1'b1;
    drive(1'b1, 8'h55, 1'b0, 1'b0);

    // Reset held two cycles with s_valid asserted
    tick();
    tick();
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_m_valid_1", {31'd0, m_valid_1}, 32'd0);
    chk("rst_m_valid_2", {31'd0, m_valid_2}, 32'd0);
    chk("rst_m_data_1", {24'd0, m_data_1}, 32'd0);
    chk("rst_m_data_2", {24'd0, m_data_2}, 32'd0);
    chk("rst_m_last_1", {31'd0, m_last_1}, 32'd0);
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    chk("rel_s_ready", {31'd0, s_ready}, 32'd1);
    chk("rel_m_valid_1", {31'd0, m_valid_1}, 32'd0);

    // Routing: 4-beat packet to port 1, one-cycle latency
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, pkt_a[k], (k == 3), 1'b0);
      #1;
      chk("route_s_ready", {31'd0, s_ready}, 32'd1);
      tick();
      chk("route_m_valid_1", {31'd0, m_valid_1}, 32'd1);
      chk("route_m_data_1", {24'd0, m_data_1}, {24'd0, pkt_a[k]});
      chk("route_m_last_1", {31'd0, m_last_1}, (k == 3) ? 32'd1 : 32'd0);
      chk("route_m_valid_2", {31'd0, m_valid_2}, 32'd0);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    chk("route_drained_1", {31'd0, m_valid_1}, 32'd0);

    // Lock: sel toggles every beat, packet must stay on port 2
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 8'hB0 + 8'(k), (k == 4), (k % 2 == 0));
      tick();
      chk("lock_m_valid_2", {31'd0, m_valid_2}, 32'd1);
      chk("lock_m_data_2", {24'd0, m_data_2}, 32'hB0 + 32'(k));
      chk("lock_m_last_2", {31'd0, m_last_2}, (k == 4) ? 32'd1 : 32'd0);
      chk("lock_m_valid_1", {31'd0, m_valid_1}, 32'd0);
    end
    drive(1'b1, 8'hC0, 1'b1, 1'b0);
    tick();
    chk("next_m_valid_1", {31'd0, m_valid_1}, 32'd1);
    chk("next_m_data_1", {24'd0, m_data_1}, 32'hC0);
    chk("next_m_last_1", {31'd0, m_last_1}, 32'd1);
    chk("next_m_valid_2", {31'd0, m_valid_2}, 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();

    // Backpressure: port 2 stalled, third beat must wait for the first pop
    m_ready_2 = 1'b0;
    drive(1'b1, 8'hA0, 1'b0, 1'b1);
    #1;
    chk("bp_ready_a0", {31'd0, s_ready}, 32'd1);
    tick();
    drive(1'b1, 8'hA1, 1'b0, 1'b0);
    #1;
    chk("bp_ready_a1", {31'd0, s_ready}, 32'd1);
    tick();
    drive(1'b1, 8'hA2, 1'b1, 1'b0);
    #1;
    chk("bp_full_ready", {31'd0, s_ready}, 32'd0);
    chk("bp_head_a0", {24'd0, m_data_2}, 32'hA0);
    tick();
    m_ready_2 = 1'b1;
    #1;
    chk("bp_no_comb_path", {31'd0, s_ready}, 32'd0);
    chk("bp_head_stable", {24'd0, m_data_2}, 32'hA0);
    chk("bp_valid_stall", {31'd0, m_valid_2}, 32'd1);
    tick();
    chk("bp_ready_after_pop", {31'd0, s_ready}, 32'd1);
    chk("bp_head_a1", {24'd0, m_data_2}, 32'hA1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("bp_head_a2", {24'd0, m_data_2}, 32'hA2);
    chk("bp_last_a2", {31'd0, m_last_2}, 32'd1);
    tick();
    chk("bp_drained_2", {31'd0, m_valid_2}, 32'd0);

    // Independent drain: port 1 full and stalled, single beat to port 2
    m_ready_1 = 1'b0;
    drive(1'b1, 8'hD0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'hD1, 1'b1, 1'b1);
    tick();
    drive(1'b1, 8'hE0, 1'b1, 1'b1);
    #1;
    chk("ind_s_ready", {31'd0, s_ready}, 32'd1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("ind_m_valid_2", {31'd0, m_valid_2}, 32'd1);
    chk("ind_m_data_2", {24'd0, m_data_2}, 32'hE0);
    chk("ind_m_last_2", {31'd0, m_last_2}, 32'd1);
    chk("ind_m_valid_1", {31'd0, m_valid_1}, 32'd1);
    chk("ind_m_data_1", {24'd0, m_data_1}, 32'hD0);
    tick();
    chk("ind_drained_2", {31'd0, m_valid_2}, 32'd0);
    chk("ind_hold_1", {24'd0, m_data_1}, 32'hD0);
    m_ready_1 = 1'b1;
    tick();
    chk("ind_d1_data", {24'd0, m_data_1}, 32'hD1);
    chk("ind_d1_last", {31'd0, m_last_1}, 32'd1);
    tick();
    chk("ind_drained_1", {31'd0, m_valid_1}, 32'd0);

    // Reset mid-packet on port 1, then a fresh packet to port 2
    m_ready_1 = 1'b0;
    drive(1'b1, 8'h61, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h62, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("mid_pre_valid_1", {31'd0, m_valid_1}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_s_ready", {31'd0, s_ready}, 32'd0);
    tick();
    chk("mid_m_valid_1", {31'd0, m_valid_1}, 32'd0);
    chk("mid_m_data_1", {24'd0, m_data_1}, 32'd0);
    reset = 1'b1;
    drive(1'b1, 8'h70, 1'b0, 1'b1);
    tick();
    chk("post_m_valid_2", {31'd0, m_valid_2}, 32'd1);
    chk("post_m_data_2", {24'd0, m_data_2}, 32'h70);
    chk("post_m_valid_1", {31'd0, m_valid_1}, 32'd0);
    drive(1'b1, 8'h71, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("post_m_data_2b", {24'd0, m_data_2}, 32'h71);
    chk("post_m_last_2b", {31'd0, m_last_2}, 32'd1);
    chk("post_m_valid_1b", {31'd0, m_valid_1}, 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_demux_1_2.md
Name: axis_demux_1_2

Overview:
- 1-to-2 AXI-Stream packet demultiplexer; the receive-side counterpart of the team's 2:1 stream mux.
- Takes one slave stream and routes whole packets to master port 1 or 2.
- `sel` is sampled at the first beat of each packet and locked until the `s_last` beat is accepted.
- Each output has a 2-entry buffer, giving full throughput and no combinational path from `m_ready_x` to `s_ready`.

Parameters:
- DATA_WIDTH, 8, width of every data bus.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
- sel  in  1  route select: 0 → port 1, 1 → port 2; only honoured at packet start
- s_data  in  DATA_WIDTH  slave data
- s_valid  in  1  slave valid
- s_ready  out  1  slave ready
- s_last  in  1  slave end-of-packet
- m_data_1  out  DATA_WIDTH  master 1 data
- m_valid_1  out  1  master 1 valid
- m_ready_1  in  1  master 1 ready
- m_last_1  out  1  master 1 end-of-packet
- m_data_2 / m_valid_2 / m_ready_2 / m_last_2: same as port 1, for master 2

Behaviour:
- Reset (reset==0 at clk edge):
  - FSM → IDLE; both buffers emptied.
  - m_valid_x=0, m_data_x=0, m_last_x=0.
  - s_ready forced 0 while reset is low.
- FSM states IDLE, PKT1, PKT2 drive dest:
  - IDLE: dest = sel (combinational).
  - PKT1: dest = 1. PKT2: dest = 2. sel is ignored in both.
- Transitions, evaluated on an accepted beat (s_valid && s_ready):
  - IDLE && !s_last → PKT(dest).
  - IDLE && s_last → stay IDLE (single-beat packet).
  - PKTx && s_last → IDLE.
  - PKTx && !s_last → stay.
- No accepted beat: state holds.
- Buffers: each output owns a 2-entry FIFO of {data, last} with count 0..2.
- s_ready = (count[dest] < 2) && reset. Derived from registers and sel only; m_ready_x never reaches s_ready.
- Accepted beat is written into buffer[dest] only; the other buffer is untouched.
- Latency: a beat accepted at edge N is presented on m_*_dest after edge N (1 cycle).
- m_valid_x = (count_x != 0). m_data_x / m_last_x = buffer head.
- Head stays stable while m_valid_x && !m_ready_x.
- Pop on m_valid_x && m_ready_x.
- Push and pop in the same cycle on the same buffer: count unchanged, order preserved. This is legal at count 1, and at count 2 only if s_ready was 1, which it is not at 2.
- Throughput: sustained 1 beat/cycle when the destination holds m_ready=1.
- Both outputs drain independently. A new packet may route to port 2 while port 1 still holds buffered beats of the previous packet.
- Full: count[dest]==2 → s_ready=0; an s_valid beat waits and s_data must be held by the source.
- Sel changes:
  - A sel change mid-packet has no effect.
  - A sel change in IDLE while s_valid && !s_ready: dest follows sel. This is legal because no beat has been accepted yet.
- Reset mid-packet: the packet is truncated. Buffered beats are discarded, no m_last is emitted, and the next accepted beat starts a new packet.
- No beat is ever dropped, duplicated, or reordered within a port.

Decomposition:
- Package `axis_pkg`:
  - DATA_WIDTH default constant.
  - State enum {IDLE, PKT1, PKT2}.
  - Port-index constants PORT_1=0, PORT_2=1.
- Sub-module `axis_fifo2`: 2-entry {data, last} buffer with push/pop/count/head. Instantiated once per output. Top level holds only the FSM, dest mux and s_ready.

Test Plan:
- Reset: hold reset=0 for 2 cycles with s_valid=1 → s_ready=0, all m_valid=0, m_data=0. Release → s_ready=1 next cycle.
- Routing: sel=0, 4-beat packet 0x11,0x22,0x33,0x44 (last on 0x44), m_ready_1=1.
  - Port 1 outputs 0x11..0x44 on consecutive cycles, 1-cycle latency, m_last_1 only on 0x44.
  - m_valid_2 stays 0.
- Lock: sel=1 at first beat, then sel toggles every cycle during a 5-beat packet → all 5 beats appear on port 2. The next packet with sel=0 goes to port 1.
- Backpressure: m_ready_2=0, 3-beat packet to port 2:
  - 2 beats accepted, then s_ready=0.
  - Raise m_ready_2 → s_ready=1 the cycle after the first pop; the third beat is delivered; order 0xA0,0xA1,0xA2 intact.
- Independent drain: port 1 holds 2 buffered beats with m_ready_1=0; a single-beat packet (s_last=1) with sel=1 → accepted immediately and delivered on port 2 while port 1 stays valid with its data unchanged.
- Reset mid-packet: reset=0 after beat 2 of a 6-beat port-1 packet → buffers cleared, m_valid_1=0. After release, a new sel=1 packet routes to port 2 and the FSM starts in IDLE.
